// File: rtl/loss_gradient_stage.sv
// loss_gradient_stage: serial per-output error gradient (prediction - target) plus batch mean squared error.
// Latency: out_valid rises output_units cycles after the accept edge; best throughput one vector per output_units+2 cycles.
// Backpressure: result is held in OUTPUT while out_ready is low; in_ready stays low until the result is taken.
// Optional feature macro: LOSS_GRADIENT_CLIP_EN clamps each gradient element to [-1.0, +1.0].

// Signed fixed point Q8.8 with saturating add/sub and a truncating (floor) multiply.
package fixed_point_pkg;
  localparam int SFP_W    = 16;
  localparam int SFP_FRAC = 8;
  typedef logic signed [SFP_W-1:0] sfp_t;
  localparam sfp_t SFP_MAX     = 16'sh7FFF;
  localparam sfp_t SFP_MIN     = 16'sh8000;
  localparam sfp_t SFP_ONE     = 16'sh0100;
  localparam sfp_t SFP_NEG_ONE = -16'sh0100;

  function automatic sfp_t sfp_sat(input logic signed [31:0] v);
    if (v > 32'sd32767) return SFP_MAX;
    else if (v < -32'sd32768) return SFP_MIN;
    else return sfp_t'(v[15:0]);
  endfunction

  function automatic sfp_t sfp_add(input sfp_t a, input sfp_t b);
    return sfp_sat(32'(a) + 32'(b));
  endfunction

  function automatic sfp_t sfp_sub(input sfp_t a, input sfp_t b);
    return sfp_sat(32'(a) - 32'(b));
  endfunction

  function automatic sfp_t sfp_mul(input sfp_t a, input sfp_t b);
    logic signed [31:0] p;
    p = 32'(a) * 32'(b);
    return sfp_sat(p >>> SFP_FRAC);
  endfunction
endpackage

module loss_gradient_stage
  import fixed_point_pkg::*;
#(
  parameter int output_units = 2,
  parameter int batch_size   = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  sfp_t [output_units-1:0]           predictions,
  input  sfp_t [output_units-1:0]           targets,
  input  logic                              clear_loss,
  output logic                              out_valid,
  input  logic                              out_ready,
  output sfp_t [output_units-1:0]           error_gradient,
  output logic                              loss_valid,
  output sfp_t                              loss,
  output logic [$clog2(batch_size+1)-1:0]   batch_count
);

  localparam int IDX_W = (output_units > 1) ? $clog2(output_units) : 1;
  localparam int BC_W  = $clog2(batch_size + 1);
  localparam int SHIFT = $clog2(batch_size);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(output_units - 1);
  localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(batch_size - 1);

  typedef enum logic [1:0] {IDLE, COMPUTE, OUTPUT} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  sfp_t             acc;
  sfp_t             pred_q [output_units];
  sfp_t             tgt_q  [output_units];
  sfp_t             d;
  sfp_t             d_sq;
  sfp_t             grad;

  // Difference and its square for the element currently addressed by idx.
  assign d    = sfp_sub(pred_q[idx], tgt_q[idx]);
  assign d_sq = sfp_mul(d, d);

`ifdef LOSS_GRADIENT_CLIP_EN
  // Clamp only the presented gradient; the loss still sees the raw difference.
  assign grad = (d > SFP_ONE) ? SFP_ONE : ((d < SFP_NEG_ONE) ? SFP_NEG_ONE : d);
`else
  assign grad = d;
`endif

  // Capture, serial compute, output hold, and batch loss bookkeeping; clear_loss overrides acc/batch_count last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      idx            <= '0;
      acc            <= '0;
      in_ready       <= 1'b1;
      out_valid      <= 1'b0;
      loss_valid     <= 1'b0;
      error_gradient <= '0;
      loss           <= '0;
      batch_count    <= '0;
      for (int i = 0; i < output_units; i++) begin
        pred_q[i] <= '0;
        tgt_q[i]  <= '0;
      end
    end else begin
      loss_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            for (int i = 0; i < output_units; i++) begin
              pred_q[i] <= predictions[i];
              tgt_q[i]  <= targets[i];
            end
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= COMPUTE;
          end
        end
        COMPUTE: begin
          error_gradient[idx] <= grad;
          acc                 <= sfp_add(acc, d_sq);
          if (idx == LAST_IDX) begin
            out_valid <= 1'b1;
            state     <= OUTPUT;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
            // A clear on the completing handshake suppresses the report entirely.
            if ((batch_count == BC_LAST) && !clear_loss) begin
              loss        <= acc >>> SHIFT;
              acc         <= '0;
              batch_count <= '0;
              loss_valid  <= 1'b1;
            end else begin
              batch_count <= batch_count + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
      if (clear_loss) begin
        acc         <= '0;
        batch_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_loss_gradient_stage.sv
`timescale 1ns/1ps
module tb_loss_gradient_stage;
  import fixed_point_pkg::*;

  localparam int UNITS = 2;
  localparam int BATCH = 4;
  localparam int SH    = 2;

  logic                           clk;
  logic                           rst_n;
  logic                           in_valid;
  logic                           in_ready;
  sfp_t [UNITS-1:0]               predictions;
  sfp_t [UNITS-1:0]               targets;
  logic                           clear_loss;
  logic                           out_valid;
  logic                           out_ready;
  sfp_t [UNITS-1:0]               error_gradient;
  logic                           loss_valid;
  sfp_t                           loss;
  logic [$clog2(BATCH+1)-1:0]     batch_count;

  loss_gradient_stage #(.output_units(UNITS), .batch_size(BATCH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .predictions(predictions), .targets(targets), .clear_loss(clear_loss),
    .out_valid(out_valid), .out_ready(out_ready), .error_gradient(error_gradient),
    .loss_valid(loss_valid), .loss(loss), .batch_count(batch_count)
  );

  typedef struct packed {
    logic [UNITS-1:0][15:0] g;
    int                     sq;
  } exp_t;

  exp_t gq[$];
  int   lq[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   ready_mode = 2;  // 0 random, 1 hold low, 2 hold high
  int   m_acc = 0, m_bc = 0, m_loss = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int clipv(input int v);
`ifdef LOSS_GRADIENT_CLIP_EN
    if (v > 256) return 256;
    if (v < -256) return -256;
`endif
    return v;
  endfunction

  // Reference: gradient = sat(p - t) (optionally clamped); loss term = sum of floor(d*d/256).
  function automatic exp_t model(input int p[UNITS], input int t[UNITS]);
    exp_t e;
    int   d;
    e.g  = '0;
    e.sq = 0;
    for (int i = 0; i < UNITS; i++) begin
      d      = sat16(p[i] - t[i]);
      e.g[i] = 16'(clipv(d));
      e.sq   = e.sq + sat16((d * d) / 256);
    end
    return e;
  endfunction

  // Consumer readiness driver.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = ($urandom_range(0, 3) != 0);
        1:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor / scoreboard.
  initial begin
    exp_t e;
    int   l;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        gq.delete();
        lq.delete();
        m_acc = 0; m_bc = 0; m_loss = 0;
      end else begin
        chk("loss_value", int'(loss), m_loss);
        chk("batch_count", int'(batch_count), m_bc);
        if (loss_valid) begin
          if (lq.size() == 0) chk("unexpected_loss_valid", 1, 0);
          else begin
            l = lq.pop_front();
            chk("loss_report", int'(loss), l);
          end
        end
        if (out_valid && out_ready) begin
          if (gq.size() == 0) chk("unexpected_output", 1, 0);
          else begin
            e = gq.pop_front();
            for (int i = 0; i < UNITS; i++)
              chk("gradient", int'(signed'(error_gradient[i])), int'(signed'(e.g[i])));
            if (clear_loss) begin
              m_acc = 0; m_bc = 0;
            end else begin
              m_acc = m_acc + e.sq;
              if (m_acc > 32767) m_acc = 32767;
              m_bc++;
              if (m_bc == BATCH) begin
                m_loss = m_acc >>> SH;
                lq.push_back(m_loss);
                m_acc = 0; m_bc = 0;
              end
            end
          end
        end else if (clear_loss) begin
          m_acc = 0; m_bc = 0;
        end
      end
    end
  end

  task automatic send(input int p[UNITS], input int t[UNITS], input bit clr);
    int n;
    @(posedge clk);
    #1;
    for (int i = 0; i < UNITS; i++) begin
      predictions[i] = 16'(p[i]);
      targets[i]     = 16'(t[i]);
    end
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready) begin
      n++;
      if (n > 200) begin
        chk("accept_timeout", 1, 0);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    @(posedge clk);
    gq.push_back(model(p, t));
    #1 in_valid = 1'b0;
    for (int k = 1; k <= UNITS; k++) begin
      @(posedge clk);
      #1;
      if (k == UNITS && clr) clear_loss = 1'b1;
      @(negedge clk);
      chk("out_valid_latency", int'(out_valid), (k == UNITS) ? 1 : 0);
    end
    if (clr) begin
      @(posedge clk);
      #1 clear_loss = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    while (!(in_ready && !out_valid)) begin
      n++;
      if (n > 200) begin
        chk("drain_timeout", 1, 0);
        return;
      end
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation stalled at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   pa[UNITS], ta[UNITS], qa[UNITS];
    exp_t es;
    rst_n = 1'b0; in_valid = 1'b0; clear_loss = 1'b0;
    predictions = '0; targets = '0;
    #23 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_loss", int'(loss), 0);
    chk("reset_batch_count", int'(batch_count), 0);
    for (int i = 0; i < UNITS; i++) chk("reset_gradient", int'(signed'(error_gradient[i])), 0);

    // Batch of four identical samples: grad {0.5,-0.25}, loss 0.3125.
    ready_mode = 2;
    pa = '{192, 64}; ta = '{64, 128};
    repeat (BATCH) send(pa, ta, 1'b0);
    drain();
    chk("batch_loss_const", int'(loss), 80);
    chk("batch_count_wrap", int'(batch_count), 0);

    // clear_loss on the completing handshake: no report, loss retained.
    for (int s = 0; s < BATCH; s++) send(pa, ta, s == BATCH - 1);
    drain();
    chk("clear_keeps_loss", int'(loss), 80);
    chk("clear_batch_count", int'(batch_count), 0);

    // Stall in OUTPUT with a pending new vector.
    ready_mode = 1;
    send(pa, ta, 1'b0);
    es = model(pa, ta);
    qa = '{-100, 300};
    @(posedge clk);
    #1;
    for (int i = 0; i < UNITS; i++) predictions[i] = 16'(qa[i]);
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_out_valid", int'(out_valid), 1);
      chk("stall_in_ready", int'(in_ready), 0);
      for (int i = 0; i < UNITS; i++)
        chk("stall_gradient", int'(signed'(error_gradient[i])), int'(signed'(es.g[i])));
    end
    ready_mode = 2;
    send(qa, ta, 1'b0);
    drain();

    // Fresh batch of large-difference samples (optional clamp).
    @(posedge clk); #1 clear_loss = 1'b1;
    @(posedge clk); #1 clear_loss = 1'b0;
    pa = '{512, -384}; ta = '{0, 0};
    for (int s = 0; s < BATCH; s++) begin
      send(pa, ta, 1'b0);
      if (s == 0) begin
`ifdef LOSS_GRADIENT_CLIP_EN
        chk("clip_grad0", int'(signed'(error_gradient[0])), 256);
        chk("clip_grad1", int'(signed'(error_gradient[1])), -256);
`else
        chk("raw_grad0", int'(signed'(error_gradient[0])), 512);
        chk("raw_grad1", int'(signed'(error_gradient[1])), -384);
`endif
      end
    end
    drain();
    chk("large_batch_loss", int'(loss), 1600);

    // Randomised traffic with random consumer readiness.
    ready_mode = 0;
    for (int s = 0; s < 40; s++) begin
      for (int i = 0; i < UNITS; i++) begin
        if ($urandom_range(0, 7) == 0) begin
          pa[i] = int'($urandom_range(0, 65535)) - 32768;
          ta[i] = int'($urandom_range(0, 65535)) - 32768;
        end else begin
          pa[i] = int'($urandom_range(0, 1023)) - 512;
          ta[i] = int'($urandom_range(0, 1023)) - 512;
        end
      end
      send(pa, ta, 1'b0);
    end
    ready_mode = 2;
    drain();

    // Asynchronous reset in the middle of COMPUTE.
    pa = '{300, -200}; ta = '{10, 20};
    @(posedge clk);
    #1;
    for (int i = 0; i < UNITS; i++) begin
      predictions[i] = 16'(pa[i]);
      targets[i]     = 16'(ta[i]);
    end
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", int'(in_ready), 1);
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_loss", int'(loss), 0);
    chk("arst_batch_count", int'(batch_count), 0);
    for (int i = 0; i < UNITS; i++) chk("arst_gradient", int'(signed'(error_gradient[i])), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    pa = '{-256, 100}; ta = '{128, -50};
    send(pa, ta, 1'b0);
    drain();
    chk("post_reset_batch_count", int'(batch_count), 1);

    chk("gradient_queue_empty", gq.size(), 0);
    chk("loss_queue_empty", lq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
